otter_wrapper_io: RTL and testbench

OTTER_WRAPPER_IO -- requirements
Module: otter_wrapper

---
 rtl/otter_wrapper_io.sv | 166 ++++++++++++++++
 tb/tb_otter_wrapper_io.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_wrapper_io.sv
// otter_wrapper_io: button event counter shown on a 4-digit hex display,
// switch-to-LED passthrough and a 640x480 VGA switch-colour pattern.
module otter_wrapper_io #(
  parameter int CLK_DIV   = 4,
  parameter int SCAN_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  buttons,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic [7:0]  segs,
  output logic [3:0]  an,
  output logic        Hsync,
  output logic        Vsync,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int SCAN_W = SCAN_BITS + 2;

  logic [4:0]  r_btn_s1, r_btn_s2;
  logic [15:0] r_sw_s1, r_sw_s2;
  logic [1:0]  r_warm;
  logic        r_armed, r_evt_prev;
  logic [15:0] r_count;
  logic        w_evt_rise;
  logic        w_unused_btn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= buttons;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= switches;
      r_sw_s2  <= r_sw_s1;
    end
  end

  assign leds         = r_sw_s2;
  assign w_unused_btn = ^r_btn_s2[3:1];

  // Counting is armed only once the synchronized button has been seen low,
  // so a button already held at reset release cannot register a press.
  assign w_evt_rise = r_btn_s2[4] & ~r_evt_prev & r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm     <= '0;
      r_armed    <= 1'b0;
      r_evt_prev <= 1'b0;
      r_count    <= '0;
    end else begin
      r_warm     <= {r_warm[0], 1'b1};
      r_evt_prev <= r_btn_s2[4];
      if (r_warm[1] && !r_btn_s2[4])
        r_armed <= 1'b1;
      if (r_btn_s2[0])
        r_count <= '0;
      else if (w_evt_rise)
        r_count <= r_count + 16'd1;
    end
  end

  logic [SCAN_W-1:0] r_scan;
  logic [1:0]        w_digit;
  logic [3:0]        w_nibble;
  logic [3:0]        w_an;
  logic [6:0]        w_seg7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_scan <= '0;
    else        r_scan <= r_scan + SCAN_W'(1);
  end

  assign w_digit = r_scan[SCAN_W-1:SCAN_BITS];

  always_comb begin
    w_an = 4'b1111;
    w_an[w_digit] = 1'b0;
    case (w_digit)
      2'd0:    w_nibble = r_count[3:0];
      2'd1:    w_nibble = r_count[7:4];
      2'd2:    w_nibble = r_count[11:8];
      default: w_nibble = r_count[15:12];
    endcase
  end

  always_comb begin
    case (w_nibble)
      4'h0:    w_seg7 = 7'b1000000;
      4'h1:    w_seg7 = 7'b1111001;
      4'h2:    w_seg7 = 7'b0100100;
      4'h3:    w_seg7 = 7'b0110000;
      4'h4:    w_seg7 = 7'b0011001;
      4'h5:    w_seg7 = 7'b0010010;
      4'h6:    w_seg7 = 7'b0000010;
      4'h7:    w_seg7 = 7'b1111000;
      4'h8:    w_seg7 = 7'b0000000;
      4'h9:    w_seg7 = 7'b0010000;
      4'hA:    w_seg7 = 7'b0001000;
      4'hB:    w_seg7 = 7'b0000011;
      4'hC:    w_seg7 = 7'b1000110;
      4'hD:    w_seg7 = 7'b0100001;
      4'hE:    w_seg7 = 7'b0000110;
      default: w_seg7 = 7'b0001110;
    endcase
  end

  assign an   = w_an;
  assign segs = {1'b1, w_seg7};

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h, r_v;
  logic             w_pix_en, w_active;
  logic             r_hsync, r_vsync;
  logic [11:0]      r_rgb;

  assign w_pix_en = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_pix_en ? '0 : r_div + DIV_W'(1);
      if (w_pix_en) begin
        if (r_h == 10'd799) begin
          r_h <= '0;
          r_v <= (r_v == 10'd524) ? 10'd0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

  assign w_active = (r_h < 10'd640) && (r_v < 10'd480);

  // Sync and colour share one register stage so they stay pixel-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= '0;
    end else begin
      r_hsync <= !((r_h >= 10'd656) && (r_h <= 10'd751));
      r_vsync <= !((r_v >= 10'd490) && (r_v <= 10'd491));
      r_rgb   <= w_active ? r_sw_s2[11:0] : 12'h000;
    end
  end

  assign Hsync    = r_hsync;
  assign Vsync    = r_vsync;
  assign vgaRed   = r_rgb[11:8];
  assign vgaGreen = r_rgb[7:4];
  assign vgaBlue  = r_rgb[3:0];

endmodule

// File: tb/tb_otter_wrapper_io.sv
// tb_otter_wrapper_io: scoreboard bench; a reference count/LED model feeds
// queues that independent monitors drain as the display and LEDs change.
module tb_otter_wrapper_io;
  localparam int CLK_DIV   = 4;
  localparam int SCAN_BITS = 1;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  buttons = '0;
  logic [15:0] switches = '0;
  logic [15:0] leds;
  logic [7:0]  segs;
  logic [3:0]  an;
  logic        Hsync, Vsync;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;

  otter_wrapper_io #(.CLK_DIV(CLK_DIV), .SCAN_BITS(SCAN_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .switches(switches),
    .leds(leds), .segs(segs), .an(an), .Hsync(Hsync), .Vsync(Vsync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_msg(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h, expected nothing pending", name, act);
  endtask

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    seg_decode = 5'h10;
    for (int n = 0; n < 16; n++)
      if (s == SEG_TAB[n]) seg_decode = {1'b0, 4'(n)};
  endfunction

  // Reference model: displayed count and LED value with its issue cycle
  typedef struct { logic [15:0] val; int c; } led_exp_t;
  logic [15:0] model_count = '0;
  logic [15:0] cnt_q [$];
  led_exp_t    led_q [$];
  int          rel_cyc = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_set(input logic [15:0] nv);
    if (nv != model_count) cnt_q.push_back(nv);
    model_count = nv;
  endtask

  task automatic press(input int w);
    model_set(model_count + 16'd1);
    buttons[4] = 1'b1;
    tick(w);
    buttons[4] = 1'b0;
  endtask

  task automatic clear_pulse(input int w);
    model_set(16'h0000);
    buttons[0] = 1'b1;
    tick(w);
    buttons[0] = 1'b0;
  endtask

  task automatic set_switches(input logic [15:0] val);
    logic [15:0] v;
    v = (val == switches) ? ~val : val;
    switches = v;
    led_q.push_back('{v, cyc});
  endtask

  task automatic reset_pulse(input int low_cycles);
    #2 rst_n = 1'b0;
    model_set(16'h0000);
    led_q.delete();
    tick(low_cycles);
    rst_n = 1'b1;
    rel_cyc = cyc;
    if (switches != 16'h0) led_q.push_back('{switches, cyc});
  endtask

  task automatic wait_an(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (an === want) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  logic [15:0] last_leds = '0;
  always @(negedge clk) begin : led_mon
    led_exp_t e;
    if (!rst_n) last_leds = 16'h0;
    else if (leds !== last_leds) begin
      if (led_q.size() == 0) fail_msg("leds_unexpected", 32'(leds));
      else begin
        e = led_q.pop_front();
        check("leds_value", 32'(leds), 32'(e.val));
        check("leds_latency", cyc - e.c, 32'd2);
      end
      last_leds = leds;
    end
  end

  // Display monitor: rebuilds the shown value once per full scan and only
  // accepts a new value after two identical scans (filters mid-scan updates).
  logic [3:0]  dnib [4];
  logic        dinv [4];
  int          d_idx = 0;
  logic [3:0]  d_prev_an = 4'b1110;
  logic [16:0] last_val = '0;
  logic [16:0] cand = '0;
  int          cand_n = 0;

  always @(negedge clk) begin : disp_mon
    logic [4:0]  dec;
    logic [3:0]  exp_an;
    logic [16:0] v;
    logic [15:0] e16;
    int          nxt;
    if (!rst_n) begin
      d_idx = 0;
      d_prev_an = 4'b1110;
      cand_n = 0;
    end else begin
      if (an !== d_prev_an) begin
        nxt = (d_idx + 1) % 4;
        exp_an = ~(4'b0001 << nxt);
        check("scan_order", {27'h0, an, segs[7]}, {27'h0, exp_an, 1'b1});
        d_prev_an = an;
        d_idx = nxt;
        if (nxt == 0) begin
          v = {dinv[0] | dinv[1] | dinv[2] | dinv[3], dnib[3], dnib[2], dnib[1], dnib[0]};
          if (v == last_val) cand_n = 0;
          else if (cand_n > 0 && v == cand) begin
            cand_n = 0;
            last_val = v;
            if (cnt_q.size() == 0) fail_msg("display_unexpected", 32'(v));
            else begin
              e16 = cnt_q.pop_front();
              check("display_count", 32'(v), {16'h0, e16});
            end
          end else begin
            cand = v;
            cand_n = 1;
          end
        end
      end
      dec = seg_decode(segs[6:0]);
      dnib[d_idx] = dec[3:0];
      dinv[d_idx] = dec[4];
    end
  end

  // VGA monitor: pixel index derived from clocks since reset release.
  bit          vga_on = 1'b0;
  int          vga_rel = 0;
  logic [15:0] vga_sw = '0;
  int          hs_fall = -1;
  logic        hs_last = 1'b1;

  always @(negedge clk) begin : vga_mon
    int i, p, h, v;
    logic hs, vs;
    logic [11:0] col;
    if (vga_on) begin
      i = cyc - vga_rel;
      if (i >= 4) begin
        p = (i - 1) / CLK_DIV;
        h = p % 800;
        v = (p / 800) % 525;
        hs = !(h >= 656 && h <= 751);
        vs = !(v >= 490 && v <= 491);
        col = (h < 640 && v < 480) ? vga_sw[11:0] : 12'h000;
        check("vga_pixel", {18'h0, Hsync, Vsync, vgaRed, vgaGreen, vgaBlue}, {18'h0, hs, vs, col});
      end
      if (hs_last && !Hsync) begin
        if (hs_fall >= 0) check("hsync_period", cyc - hs_fall, 32'd3200);
        hs_fall = cyc;
      end
      if (!hs_last && Hsync && hs_fall >= 0) check("hsync_width", cyc - hs_fall, 32'd384);
      hs_last = Hsync;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit ok;
    int op;
    #2 rst_n = 1'b0;
    tick(3);
    check("rst_leds",  32'(leds), 32'h0000);
    check("rst_an",    32'(an), 32'b1110);
    check("rst_segs",  32'(segs), 32'hC0);
    check("rst_hsync", 32'(Hsync), 32'd1);
    check("rst_vsync", 32'(Vsync), 32'd1);
    check("rst_rgb",   {20'h0, vgaRed, vgaGreen, vgaBlue}, 32'h0);
    rst_n = 1'b1;
    tick(10);

    for (int k = 0; k < 4; k++) begin
      press(3);
      tick(40);
    end
    wait_an(4'b1110, ok);
    if (!ok) fail_msg("wait_digit0_timeout", 32'(an));
    else check("digit0_is_4", 32'(segs), 32'h99);
    for (int k = 1; k < 4; k++) begin
      wait_an(~(4'b0001 << k), ok);
      if (!ok) fail_msg("wait_digit_timeout", 32'(an));
      else check("upper_digit_is_0", 32'(segs), 32'hC0);
    end

    press(100);
    tick(40);

    clear_pulse(3);
    tick(30);
    for (int k = 0; k < 3; k++) begin
      press(2);
      tick(30);
    end
    model_set(16'h0000);
    buttons[0] = 1'b1;
    buttons[4] = 1'b1;
    tick(3);
    buttons[0] = 1'b0;
    buttons[4] = 1'b0;
    tick(30);
    press(2);
    tick(30);

    buttons[4] = 1'b1;
    reset_pulse(3);
    tick(20);
    buttons[4] = 1'b0;
    tick(30);
    press(2);
    tick(30);

    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      if (op < 6)      press($urandom_range(1, 8));
      else if (op < 7) clear_pulse($urandom_range(1, 4));
      else             set_switches(16'($urandom));
      tick(30);
    end

    switches = 16'h0ABC;
    reset_pulse(3);
    vga_sw  = switches;
    vga_rel = rel_cyc;
    hs_fall = -1;
    hs_last = 1'b1;
    vga_on  = 1'b1;
    tick(7000);
    vga_on  = 1'b0;

    #2 rst_n = 1'b0;
    model_set(16'h0000);
    led_q.delete();
    #1;
    check("midline_rst_leds",  32'(leds), 32'h0000);
    check("midline_rst_an",    32'(an), 32'b1110);
    check("midline_rst_segs",  32'(segs), 32'hC0);
    check("midline_rst_sync",  {30'h0, Hsync, Vsync}, 32'b11);
    check("midline_rst_rgb",   {20'h0, vgaRed, vgaGreen, vgaBlue}, 32'h0);
    tick(3);
    rst_n = 1'b1;
    led_q.push_back('{switches, cyc});
    tick(60);

    check("display_queue_drained", cnt_q.size(), 32'd0);
    check("leds_queue_drained", led_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
